// File: rtl/memory_stage_if.sv
// EX/MEM -> memory stage -> MEM/WB signal bundle, with state/sp debug taps.
// The master is the pipeline side that drives the *In controls; the slave is memory_stage.
interface memory_stage_if;
    logic        writeBackEnIn;
    logic        memReadIn;
    logic        memWriteIn;
    logic        pushEnIn;
    logic        popEnIn;
    logic [31:0] addressIn;
    logic [31:0] storeValueIn;
    logic [3:0]  destinationIn;

    logic        writeBackEn;
    logic        memRead;
    logic        pushEn;
    logic        popEn;
    logic [31:0] address;
    logic [3:0]  destination;
    logic [31:0] memOut;
    logic        freeze;
    logic        stackError;

    logic [1:0]  dbg_state;
    logic [31:0] dbg_sp;

    // Handshake: freeze high means "not ready"; the master holds every *In signal
    // stable until freeze drops, and the result is valid on that same cycle (DONE).
    modport master (
        output writeBackEnIn, memReadIn, memWriteIn, pushEnIn, popEnIn,
               addressIn, storeValueIn, destinationIn,
        input  writeBackEn, memRead, pushEn, popEn, address, destination,
               memOut, freeze, stackError, dbg_state, dbg_sp
    );

    modport slave (
        input  writeBackEnIn, memReadIn, memWriteIn, pushEnIn, popEnIn,
               addressIn, storeValueIn, destinationIn,
        output writeBackEn, memRead, pushEn, popEn, address, destination,
               memOut, freeze, stackError, dbg_state, dbg_sp
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: multi-cycle word load/store against internal RAM, freezing upstream.
// Optional stack push/pop (sp, stackError) is built only when MEM_STACK_EN is defined.
module memory_stage #(
    parameter int unsigned MEM_WORDS   = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    memory_stage_if.slave  bus
);
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      mem_out_q, mem_out_d;
    logic [31:0]      mem_q [MEM_WORDS];

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [31:0]      mem_wdata;
    logic [AW-1:0]    idx;
    logic             stack_req;
    logic             req;
    logic             commit;
    logic             ls_ok;

    assign idx     = AW'((bus.addressIn - BASE_ADDR) >> 2);
    assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef MEM_STACK_EN
    localparam int SP_W = AW + 1;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            stack_err_q, stack_err_d;

    assign stack_req = bus.pushEnIn | bus.popEnIn;
`else
    logic unused_stack_inputs;
    assign unused_stack_inputs = bus.pushEnIn ^ bus.popEnIn;
    assign stack_req = 1'b0;
`endif

    assign req = bus.memReadIn | bus.memWriteIn | stack_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(WAIT_CYCLES)) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A commit landing on a reset edge is dropped: every write below is gated by !rst.
    always_comb begin
        mem_out_d = mem_out_q;
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = bus.storeValueIn;
        ls_ok     = 1'b1;
`ifdef MEM_STACK_EN
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        if (commit && !rst && stack_req) begin
            ls_ok = 1'b0;
            if (bus.pushEnIn && bus.popEnIn) begin
                stack_err_d = 1'b1;
            end else if (bus.pushEnIn) begin
                if (sp_q == '0) begin
                    stack_err_d = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = AW'(sp_q - SP_W'(1));
                    sp_d      = sp_q - SP_W'(1);
                end
            end else begin
                if (sp_q == SP_W'(MEM_WORDS)) begin
                    mem_out_d   = '0;
                    stack_err_d = 1'b1;
                end else begin
                    mem_out_d = mem_q[sp_q[AW-1:0]];
                    sp_d      = sp_q + SP_W'(1);
                end
            end
        end
`endif
        if (commit && !rst && ls_ok) begin
            if (bus.memWriteIn) begin
                mem_we = 1'b1;
            end else if (bus.memReadIn) begin
                mem_out_d = mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_out_q <= mem_out_d;
        end
    end

`ifdef MEM_STACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q        <= SP_W'(MEM_WORDS);
            stack_err_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
        end
    end
`endif

    // RAM contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.writeBackEn = ~rst & bus.writeBackEnIn;
    assign bus.memRead     = ~rst & bus.memReadIn;
    assign bus.address     = rst ? 32'd0 : bus.addressIn;
    assign bus.destination = rst ? 4'd0 : bus.destinationIn;
    assign bus.memOut      = mem_out_q;
    assign bus.freeze      = ~rst & req & (state_q != DONE);
    assign bus.dbg_state   = state_q;

`ifdef MEM_STACK_EN
    assign bus.pushEn     = ~rst & bus.pushEnIn;
    assign bus.popEn      = ~rst & bus.popEnIn;
    assign bus.stackError = stack_err_q;
    assign bus.dbg_sp     = 32'(sp_q);
`else
    assign bus.pushEn     = 1'b0;
    assign bus.popEn      = 1'b0;
    assign bus.stackError = 1'b0;
    assign bus.dbg_sp     = 32'd0;
`endif
endmodule
